// File: rtl/quad_dec_if.sv
// Encoder inputs, control and decoded outputs of the quadrature decoder.
// The bench drives through master; the decoder uses slave.
interface quad_dec_if;
  logic       a_in;
  logic       b_in;
  logic       en;
  logic       err_clr;
  logic       step;
  logic       up;
  logic       err;
  logic       err_sticky;
  logic [1:0] ab_q;

  modport master (
    output a_in, b_in, en, err_clr,
    input  step, up, err, err_sticky, ab_q
  );

  modport slave (
    input  a_in, b_in, en, err_clr,
    output step, up, err, err_sticky, ab_q
  );
endinterface

// File: rtl/quad_dec.sv
// Quadrature decoder: synchronises and glitch-filters A/B, then emits step/direction
// pulses for an up/down counter and flags illegal double-bit transitions.
module quad_dec #(
  parameter int FILT = 4
) (
  input logic       clk,
  input logic       clr_n,
  quad_dec_if.slave bus
);

  typedef enum logic {INIT, TRACK} state_e;

  localparam logic [7:0] FiltLast = 8'(FILT - 1);

  state_e     state_q;
  logic [1:0] s1_q, s2_q;
  logic [1:0] ab_q, abPrev_q;
  logic [1:0] initCnt_q;
  logic [7:0] cntA_q, cntB_q;
  logic       step_q, up_q, err_q, sticky_q;

  logic [1:0] ab_d;
  logic [7:0] cntA_d, cntB_d;
  logic       isFwd, isRev, isDbl;

  // Gray-code successor in the forward direction 00->01->11->10->00.
  function automatic logic [1:0] fwdNext(input logic [1:0] x);
    case (x)
      2'b00:   fwdNext = 2'b01;
      2'b01:   fwdNext = 2'b11;
      2'b11:   fwdNext = 2'b10;
      default: fwdNext = 2'b00;
    endcase
  endfunction

  always_comb begin
    ab_d   = ab_q;
    cntA_d = cntA_q;
    cntB_d = cntB_q;

    if (s2_q[1] == ab_q[1]) begin
      cntA_d = 8'd0;
    end else if (cntA_q == FiltLast) begin
      ab_d[1] = s2_q[1];
      cntA_d  = 8'd0;
    end else begin
      cntA_d = cntA_q + 8'd1;
    end

    if (s2_q[0] == ab_q[0]) begin
      cntB_d = 8'd0;
    end else if (cntB_q == FiltLast) begin
      ab_d[0] = s2_q[0];
      cntB_d  = 8'd0;
    end else begin
      cntB_d = cntB_q + 8'd1;
    end

    isFwd = (ab_q == fwdNext(abPrev_q));
    isRev = (abPrev_q == fwdNext(ab_q));
    isDbl = ((ab_q ^ abPrev_q) == 2'b11);
  end

  // Transitions are classified one edge after ab_q moves, by comparing against abPrev_q.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= INIT;
      s1_q      <= 2'b00;
      s2_q      <= 2'b00;
      ab_q      <= 2'b00;
      abPrev_q  <= 2'b00;
      initCnt_q <= 2'd0;
      cntA_q    <= 8'd0;
      cntB_q    <= 8'd0;
      step_q    <= 1'b0;
      up_q      <= 1'b1;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      s1_q   <= {bus.a_in, bus.b_in};
      s2_q   <= s1_q;
      step_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        INIT: begin
          if (initCnt_q == 2'd2) begin
            ab_q     <= s2_q;
            abPrev_q <= s2_q;
            cntA_q   <= 8'd0;
            cntB_q   <= 8'd0;
            state_q  <= TRACK;
          end else begin
            initCnt_q <= initCnt_q + 2'd1;
          end
        end
        TRACK: begin
          ab_q     <= ab_d;
          abPrev_q <= ab_q;
          cntA_q   <= cntA_d;
          cntB_q   <= cntB_d;
          if (bus.en) begin
            if (isFwd || isRev) begin
              step_q <= 1'b1;
              up_q   <= isFwd;
            end
            if (isDbl) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= INIT;
      endcase

      if (state_q == TRACK && bus.en && isDbl) begin
        sticky_q <= 1'b1;
      end else if (bus.err_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign bus.step       = step_q;
  assign bus.up         = up_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.ab_q       = ab_q;

endmodule

// File: tb/tb_quad_dec.sv
// Directed-vector bench for quad_dec: a FILT=2 instance for the main checks and a
// FILT=1 instance sharing the same inputs for the short-glitch case.
`timescale 1ns/1ps
module tb_quad_dec;

  logic clk = 1'b0;
  logic clr_n;
  int   vecCount = 0;
  int   missCount = 0;

  quad_dec_if if2();
  quad_dec_if if1();

  quad_dec #(.FILT(2)) dut2 (.clk(clk), .clr_n(clr_n), .bus(if2.slave));
  quad_dec #(.FILT(1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(if1.slave));

  always #5 clk = ~clk;

  logic [1:0] fwdSeq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] revSeq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ab);
    if2.a_in = ab[1];
    if2.b_in = ab[0];
    if1.a_in = ab[1];
    if1.b_in = ab[0];
  endtask

  task automatic setEn(input logic val);
    if2.en = val;
    if1.en = val;
  endtask

  task automatic setErrClr(input logic val);
    if2.err_clr = val;
    if1.err_clr = val;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Applies one AB value, expects a step from the FILT=2 decoder 5 edges later, holds 10 cycles.
  task automatic expectStep(input string tag, input logic [1:0] ab, input logic upExp);
    applyStimulus(ab);
    waitEdges(4);
    checkOutput({tag, " step early"}, {7'd0, if2.step}, 8'd0);
    waitEdges(1);
    checkOutput({tag, " step"}, {7'd0, if2.step}, 8'd1);
    checkOutput({tag, " up"}, {7'd0, if2.up}, {7'd0, upExp});
    waitEdges(1);
    checkOutput({tag, " step width"}, {7'd0, if2.step}, 8'd0);
    checkOutput({tag, " ab"}, {6'd0, if2.ab_q}, {6'd0, ab});
    waitEdges(4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr_n = 1'b0;
    setEn(1'b1);
    setErrClr(1'b0);
    applyStimulus(2'b11);

    waitEdges(2);
    checkOutput("rst step", {7'd0, if2.step}, 8'd0);
    checkOutput("rst up", {7'd0, if2.up}, 8'd1);
    checkOutput("rst err", {7'd0, if2.err}, 8'd0);
    checkOutput("rst sticky", {7'd0, if2.err_sticky}, 8'd0);
    checkOutput("rst ab", {6'd0, if2.ab_q}, 8'd0);

    clr_n = 1'b1;
    waitEdges(2);
    checkOutput("init ab before load", {6'd0, if2.ab_q}, 8'd0);
    waitEdges(1);
    checkOutput("init ab loaded", {6'd0, if2.ab_q}, 8'h3);
    checkOutput("init ab loaded f1", {6'd0, if1.ab_q}, 8'h3);
    for (int i = 0; i < 4; i++) begin
      waitEdges(1);
      checkOutput("init no step", {7'd0, if2.step}, 8'd0);
      checkOutput("init no err", {7'd0, if2.err}, 8'd0);
    end

    clr_n = 1'b0;
    applyStimulus(2'b00);
    #1;
    checkOutput("async rst ab", {6'd0, if2.ab_q}, 8'd0);
    waitEdges(1);
    clr_n = 1'b1;
    waitEdges(6);

    for (int i = 0; i < 4; i++) expectStep($sformatf("fwd%0d", i), fwdSeq[i], 1'b1);
    for (int i = 0; i < 4; i++) expectStep($sformatf("rev%0d", i), revSeq[i], 1'b0);
    waitEdges(5);
    checkOutput("rev up holds", {7'd0, if2.up}, 8'd0);

    applyStimulus(2'b11);
    waitEdges(4);
    checkOutput("dbl err early", {7'd0, if2.err}, 8'd0);
    waitEdges(1);
    checkOutput("dbl err", {7'd0, if2.err}, 8'd1);
    checkOutput("dbl step", {7'd0, if2.step}, 8'd0);
    checkOutput("dbl up", {7'd0, if2.up}, 8'd0);
    checkOutput("dbl sticky", {7'd0, if2.err_sticky}, 8'd1);
    waitEdges(1);
    checkOutput("dbl err width", {7'd0, if2.err}, 8'd0);
    checkOutput("dbl sticky hold", {7'd0, if2.err_sticky}, 8'd1);
    setErrClr(1'b1);
    waitEdges(1);
    setErrClr(1'b0);
    checkOutput("err_clr sticky", {7'd0, if2.err_sticky}, 8'd0);

    applyStimulus(2'b01);
    waitEdges(10);
    applyStimulus(2'b00);
    waitEdges(10);
    checkOutput("back to 00", {6'd0, if2.ab_q}, 8'd0);
    checkOutput("back to 00 f1", {6'd0, if1.ab_q}, 8'd0);

    applyStimulus(2'b10);
    waitEdges(1);
    applyStimulus(2'b00);
    waitEdges(2);
    checkOutput("glitch f1 step early", {7'd0, if1.step}, 8'd0);
    checkOutput("glitch f1 ab", {6'd0, if1.ab_q}, 8'h2);
    waitEdges(1);
    checkOutput("glitch f1 step", {7'd0, if1.step}, 8'd1);
    checkOutput("glitch f1 up", {7'd0, if1.up}, 8'd0);
    waitEdges(1);
    checkOutput("glitch f1 step back", {7'd0, if1.step}, 8'd1);
    checkOutput("glitch f1 up back", {7'd0, if1.up}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("glitch f2 step", {7'd0, if2.step}, 8'd0);
      checkOutput("glitch f2 err", {7'd0, if2.err}, 8'd0);
      checkOutput("glitch f2 ab", {6'd0, if2.ab_q}, 8'd0);
      waitEdges(1);
    end
    waitEdges(5);

    expectStep("en step1", 2'b01, 1'b1);
    setEn(1'b0);
    applyStimulus(2'b11);
    waitEdges(5);
    checkOutput("en0 step", {7'd0, if2.step}, 8'd0);
    waitEdges(5);
    checkOutput("en0 ab tracks", {6'd0, if2.ab_q}, 8'h3);
    setEn(1'b1);
    waitEdges(3);
    checkOutput("en1 no stale step", {7'd0, if2.step}, 8'd0);

    applyStimulus(2'b01);
    waitEdges(4);
    checkOutput("pre-rst ab", {6'd0, if2.ab_q}, 8'h1);
    checkOutput("pre-rst f1 step", {7'd0, if1.step}, 8'd1);
    #3;
    clr_n = 1'b0;
    #1;
    checkOutput("midrst ab", {6'd0, if2.ab_q}, 8'd0);
    checkOutput("midrst f1 step", {7'd0, if1.step}, 8'd0);
    checkOutput("midrst f1 up", {7'd0, if1.up}, 8'd1);
    checkOutput("midrst f1 ab", {6'd0, if1.ab_q}, 8'd0);
    checkOutput("midrst err", {7'd0, if2.err}, 8'd0);
    checkOutput("midrst sticky", {7'd0, if2.err_sticky}, 8'd0);
    waitEdges(1);
    checkOutput("midrst step discarded", {7'd0, if2.step}, 8'd0);
    checkOutput("midrst up", {7'd0, if2.up}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
